// File: rtl/kvadd2_job_scheduler.sv
// Round-robin job scheduler that splits requester jobs into chunks and launches a shared kvadd2 datapath.
// Optional performance counters are built when KVADD2_SCHED_PERF_EN is defined.
module kvadd2_job_scheduler #(
    parameter int C_NUM_REQ          = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_CHUNK_BYTES      = 4096
) (
    input  logic                                      aclk,
    input  logic                                      areset_n,
    input  logic [C_NUM_REQ-1:0]                      req_valid,
    output logic [C_NUM_REQ-1:0]                      req_ready,
    input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_addr_offset,
    input  logic [C_NUM_REQ*C_XFER_SIZE_WIDTH-1:0]    req_xfer_size,
    input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]    req_constant,
    output logic [C_NUM_REQ-1:0]                      cpl_valid,
    output logic                                      dp_ap_start,
    input  logic                                      dp_ap_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]             dp_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]              dp_xfer_size,
    output logic [C_ADDER_BIT_WIDTH-1:0]              dp_constant,
    output logic                                      busy,
    output logic [$clog2(C_NUM_REQ)-1:0]              cur_req,
    output logic                                      err_spurious_done,
    output logic [31:0]                               perf_cycles,
    output logic [31:0]                               perf_jobs
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int XW = C_XFER_SIZE_WIDTH;
    localparam int CW = C_ADDER_BIT_WIDTH;
    localparam int RW = $clog2(C_NUM_REQ);
    localparam logic [XW-1:0] CHUNK = XW'(C_CHUNK_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CPL
    } state_t;

    state_t state_q, state_d;

    logic [RW-1:0]        last_grant_q;
    logic [RW-1:0]        cur_q;
    logic [RW-1:0]        cur_d;
    logic [RW-1:0]        grant;
    logic [RW-1:0]        cand;
    logic                 found;
    logic                 hs;

    logic [AW-1:0]        off_q, off_d;
    logic [XW-1:0]        rem_q, rem_d;
    logic [CW-1:0]        const_q, const_d;
    logic [XW-1:0]        next_chunk;

    logic [AW-1:0]        grant_off;
    logic [XW-1:0]        grant_size;
    logic [CW-1:0]        grant_const;

    logic [AW-1:0]        dp_off_q;
    logic [XW-1:0]        dp_size_q;
    logic [CW-1:0]        dp_const_q;
    logic                 dp_start_q;
    logic [C_NUM_REQ-1:0] cpl_q;
    logic                 err_q;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= C_NUM_REQ; i++) begin
            cand = RW'((32'(last_grant_q) + i) % C_NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign hs          = (state_q == IDLE) && found;
    assign cur_d       = hs ? grant : cur_q;
    assign grant_off   = req_addr_offset[grant*AW +: AW];
    assign grant_size  = req_xfer_size[grant*XW +: XW];
    assign grant_const = req_constant[grant*CW +: CW];

    always_comb begin
        req_ready = '0;
        if (hs && areset_n) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        rem_d   = rem_q;
        const_d = const_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    off_d   = grant_off;
                    rem_d   = grant_size;
                    const_d = grant_const;
                    state_d = (grant_size == '0) ? CPL : LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (dp_ap_done) begin
                    off_d   = off_q + AW'(dp_size_q);
                    rem_d   = rem_q - dp_size_q;
                    state_d = (rem_d == '0) ? CPL : LAUNCH;
                end
            end
            CPL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        next_chunk = (rem_d > CHUNK) ? CHUNK : rem_d;
    end

    // dp_* and cpl_valid are computed from next-state so they land registered in the matching state.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            last_grant_q <= RW'(C_NUM_REQ - 1);
            cur_q        <= '0;
            off_q        <= '0;
            rem_q        <= '0;
            const_q      <= '0;
            dp_off_q     <= '0;
            dp_size_q    <= '0;
            dp_const_q   <= '0;
            dp_start_q   <= 1'b0;
            cpl_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            rem_q      <= rem_d;
            const_q    <= const_d;
            dp_start_q <= (state_d == LAUNCH);
            if (state_d == LAUNCH) begin
                dp_off_q   <= off_d;
                dp_size_q  <= next_chunk;
                dp_const_q <= const_d;
            end
            cpl_q <= '0;
            if (state_d == CPL) begin
                cpl_q[cur_d] <= 1'b1;
            end
            if (hs) begin
                cur_q <= grant;
            end
            if (state_q == CPL) begin
                last_grant_q <= cur_q;
            end
            if (dp_ap_done && (state_q != WAIT)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign dp_ap_start       = dp_start_q;
    assign dp_addr_offset    = dp_off_q;
    assign dp_xfer_size      = dp_size_q;
    assign dp_constant       = dp_const_q;
    assign cpl_valid         = cpl_q;
    assign busy              = (state_q != IDLE);
    assign cur_req           = cur_q;
    assign err_spurious_done = err_q;

`ifdef KVADD2_SCHED_PERF_EN
    logic [31:0] job_cyc_q;
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_jobs_q;

    // Counter starts at 1 so the handshake cycle itself is included in the job length.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            job_cyc_q     <= '0;
            perf_cycles_q <= '0;
            perf_jobs_q   <= '0;
        end else begin
            if (hs) begin
                job_cyc_q <= 32'd1;
            end else if (state_q != IDLE) begin
                job_cyc_q <= job_cyc_q + 32'd1;
            end
            if (state_q == CPL) begin
                perf_cycles_q <= job_cyc_q + 32'd1;
                perf_jobs_q   <= perf_jobs_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_jobs   = perf_jobs_q;
`else
    assign perf_cycles = '0;
    assign perf_jobs   = '0;
`endif

endmodule

// File: tb/tb_kvadd2_job_scheduler.sv
// Self-checking bench for kvadd2_job_scheduler: directed and random jobs against an event-level reference model.
module tb_kvadd2_job_scheduler;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int XW = 32;
    localparam int CW = 32;
    localparam int CH = 4096;

    logic              aclk = 1'b0;
    logic              areset_n = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr_offset;
    logic [N*XW-1:0]   req_xfer_size;
    logic [N*CW-1:0]   req_constant;
    logic [N-1:0]      cpl_valid;
    logic              dp_ap_start;
    logic              dp_ap_done = 1'b0;
    logic [AW-1:0]     dp_addr_offset;
    logic [XW-1:0]     dp_xfer_size;
    logic [CW-1:0]     dp_constant;
    logic              busy;
    logic [1:0]        cur_req;
    logic              err_spurious_done;
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_jobs;

    kvadd2_job_scheduler #(
        .C_NUM_REQ(N),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_XFER_SIZE_WIDTH(XW),
        .C_ADDER_BIT_WIDTH(CW),
        .C_CHUNK_BYTES(CH)
    ) dut (
        .aclk(aclk),
        .areset_n(areset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr_offset(req_addr_offset),
        .req_xfer_size(req_xfer_size),
        .req_constant(req_constant),
        .cpl_valid(cpl_valid),
        .dp_ap_start(dp_ap_start),
        .dp_ap_done(dp_ap_done),
        .dp_addr_offset(dp_addr_offset),
        .dp_xfer_size(dp_xfer_size),
        .dp_constant(dp_constant),
        .busy(busy),
        .cur_req(cur_req),
        .err_spurious_done(err_spurious_done),
        .perf_cycles(perf_cycles),
        .perf_jobs(perf_jobs)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] j_off   [N];
    logic [XW-1:0] j_size  [N];
    logic [CW-1:0] j_const [N];
    bit            j_pend  [N];
    int            j_raise [N];

    int            cyc = 0;
    int            done_at = -1;
    int            lat_fix = 5;
    bit            lat_rand = 1'b0;
    bit            inj = 1'b0;

    bit            m_busy = 1'b0;
    int            m_owner = 0;
    logic [AW-1:0] m_off;
    longint        m_rem;
    logic [CW-1:0] m_const;
    logic [XW-1:0] m_chunk;
    logic [AW-1:0] m_chunk_off;
    bit            m_launched = 1'b0;
    int            m_exp_start = -1;
    int            m_exp_cpl = -1;
    int            m_last_grant = N - 1;
    bit            m_err = 1'b0;
    int            hs_cyc = 0;
    int            last_cycles = 0;
    int            jobs_total = 0;
    int            grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]                = j_pend[i];
            req_addr_offset[i*AW +: AW] = j_off[i];
            req_xfer_size[i*XW +: XW]   = j_size[i];
            req_constant[i*CW +: CW]    = j_const[i];
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last_grant + k) % N;
            if (j_pend[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit work_left();
        bit w;
        w = m_busy || (done_at >= 0);
        for (int i = 0; i < N; i++) begin
            if (j_pend[i] || (j_raise[i] >= 0)) w = 1'b1;
        end
        return w;
    endfunction

    task automatic step();
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_cpl;
        logic [XW-1:0] exp_chunk;
        bit            model_done;
        int            p;
        @(negedge aclk);
        if (cyc == m_exp_start) begin
            chk("dp_ap_start", 64'(dp_ap_start), 64'd1);
            exp_chunk = (m_rem > CH) ? XW'(CH) : XW'(m_rem);
            chk("dp_addr_offset", dp_addr_offset, m_off);
            chk("dp_xfer_size", 64'(dp_xfer_size), 64'(exp_chunk));
            chk("dp_constant", 64'(dp_constant), 64'(m_const));
            m_chunk     = exp_chunk;
            m_chunk_off = m_off;
            m_launched  = 1'b1;
            done_at     = cyc + (lat_rand ? int'($urandom_range(1, 8)) : lat_fix);
            m_exp_start = -1;
        end else begin
            chk("dp_ap_start_idle", 64'(dp_ap_start), 64'd0);
            if (m_launched) begin
                chk("dp_hold_size", 64'(dp_xfer_size), 64'(m_chunk));
                chk("dp_hold_offset", dp_addr_offset, m_chunk_off);
            end
        end
        exp_cpl = '0;
        if (cyc == m_exp_cpl) exp_cpl[m_owner] = 1'b1;
        chk("cpl_valid", 64'(cpl_valid), 64'(exp_cpl));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("err_spurious_done", 64'(err_spurious_done), 64'(m_err));
        if (m_busy) chk("cur_req", 64'(cur_req), 64'(m_owner));

        model_done = (cyc == done_at);
        if (dp_ap_done && !model_done) m_err = 1'b1;
        if (model_done) begin
            m_off      = m_off + AW'(m_chunk);
            m_rem      = m_rem - longint'(m_chunk);
            m_launched = 1'b0;
            done_at    = -1;
            if (m_rem == 0) m_exp_cpl = cyc + 1;
            else            m_exp_start = cyc + 1;
        end

        exp_rdy = '0;
        p = -1;
        if (!m_busy) begin
            p = rr_pick();
            if (p >= 0) exp_rdy[p] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));

        if (cyc == m_exp_cpl) begin
            m_last_grant = m_owner;
            m_busy       = 1'b0;
            m_exp_cpl    = -1;
            jobs_total++;
            last_cycles  = cyc - hs_cyc + 1;
        end
        if (p >= 0) begin
            m_busy    = 1'b1;
            m_owner   = p;
            m_off     = j_off[p];
            m_rem     = longint'(j_size[p]);
            m_const   = j_const[p];
            hs_cyc    = cyc;
            grant_log.push_back(p);
            j_pend[p] = 1'b0;
            if (j_size[p] == '0) m_exp_cpl = cyc + 1;
            else                 m_exp_start = cyc + 1;
        end

        @(posedge aclk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (j_raise[i] == cyc) begin
                j_pend[i]  = 1'b1;
                j_raise[i] = -1;
            end
        end
        drive();
        dp_ap_done = (done_at == cyc) || inj;
        inj = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int t;
        t = 0;
        while (work_left() && (t < budget)) begin
            step();
            t++;
        end
        n_cmp++;
        assert (t < budget) else begin
            n_bad++;
            $error("FAIL run_timeout: observed %0d cycles expected fewer than %0d", t, budget);
        end
    endtask

    task automatic check_perf();
`ifdef KVADD2_SCHED_PERF_EN
        chk("perf_cycles", 64'(perf_cycles), 64'(last_cycles));
        chk("perf_jobs", 64'(perf_jobs), 64'(jobs_total));
`else
        chk("perf_cycles_off", 64'(perf_cycles), 64'd0);
        chk("perf_jobs_off", 64'(perf_jobs), 64'd0);
`endif
    endtask

    task automatic do_reset();
        areset_n   = 1'b0;
        dp_ap_done = 1'b0;
        inj        = 1'b0;
        for (int i = 0; i < N; i++) begin
            j_pend[i]  = 1'b0;
            j_raise[i] = -1;
        end
        drive();
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
        chk("rst_dp_ap_start", 64'(dp_ap_start), 64'd0);
        chk("rst_dp_addr_offset", dp_addr_offset, 64'd0);
        chk("rst_dp_xfer_size", 64'(dp_xfer_size), 64'd0);
        chk("rst_dp_constant", 64'(dp_constant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur_req", 64'(cur_req), 64'd0);
        chk("rst_err", 64'(err_spurious_done), 64'd0);
        chk("rst_perf_cycles", 64'(perf_cycles), 64'd0);
        chk("rst_perf_jobs", 64'(perf_jobs), 64'd0);
        m_busy       = 1'b0;
        m_last_grant = N - 1;
        m_err        = 1'b0;
        m_exp_start  = -1;
        m_exp_cpl    = -1;
        m_launched   = 1'b0;
        done_at      = -1;
        jobs_total   = 0;
        last_cycles  = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic set_job(input int r, input logic [AW-1:0] off, input logic [XW-1:0] size);
        j_off[r]   = off;
        j_size[r]  = size;
        j_const[r] = $urandom;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord[4];
        for (int i = 0; i < N; i++) begin
            j_off[i]   = '0;
            j_size[i]  = '0;
            j_const[i] = '0;
            j_pend[i]  = 1'b0;
            j_raise[i] = -1;
        end
        drive();
        do_reset();

        // One-chunk job timed for the perf counter: start at 1, done at 10, cpl at 11.
        lat_rand = 1'b0;
        lat_fix  = 9;
        set_job(0, 64'h0000_0000_0000_4000, 32'd1024);
        j_pend[0] = 1'b1;
        drive();
        run_until_idle(200);
        step();
`ifdef KVADD2_SCHED_PERF_EN
        chk("perf_cycles_12", 64'(perf_cycles), 64'd12);
        chk("perf_jobs_1", 64'(perf_jobs), 64'd1);
`else
        chk("perf_cycles_0", 64'(perf_cycles), 64'd0);
        chk("perf_jobs_0", 64'(perf_jobs), 64'd0);
`endif

        // Two full chunks with a 20-cycle datapath.
        lat_fix = 20;
        set_job(0, 64'h0000_0000_1000_0000, 32'd8192);
        j_pend[0] = 1'b1;
        drive();
        run_until_idle(300);
        check_perf();

        // Partial last chunk: 4096 then 904.
        lat_fix = 7;
        set_job(1, 64'h0000_0000_2000_0040, 32'd5000);
        j_pend[1] = 1'b1;
        drive();
        run_until_idle(300);
        check_perf();

        // Zero-size job from requester 2: no launch, completion one cycle after handshake.
        set_job(2, 64'h0000_0000_0000_1234, 32'd0);
        j_pend[2] = 1'b1;
        drive();
        run_until_idle(50);
        check_perf();

        // Round-robin order after reset: 0, 2, then 0 and 1 raised while 2 runs.
        do_reset();
        grant_log.delete();
        lat_fix = 5;
        set_job(0, 64'h0000_0000_0001_0000, 32'd4096);
        set_job(2, 64'h0000_0000_0002_0000, 32'd4096);
        j_pend[0]  = 1'b1;
        j_pend[2]  = 1'b1;
        drive();
        j_raise[0] = cyc + 12;
        j_raise[1] = cyc + 12;
        run_until_idle(300);
        exp_ord = '{0, 2, 0, 1};
        chk("rr_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) chk("rr_order", 64'(grant_log[i]), 64'(exp_ord[i]));
        end

        // Spurious done while idle.
        repeat (2) step();
        inj = 1'b1;
        repeat (4) step();
        chk("err_sticky", 64'(err_spurious_done), 64'd1);
        chk("err_idle_busy", 64'(busy), 64'd0);

        // Random jobs, including sizes that are zero, partial or multi-chunk and offsets near the wrap point.
        lat_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                logic [AW-1:0] off;
                logic [XW-1:0] sz;
                case ($urandom % 5)
                    0:       sz = 32'd0;
                    1:       sz = 32'($urandom_range(1, 4096));
                    2:       sz = 32'(4096 * $urandom_range(1, 3));
                    3:       sz = 32'($urandom_range(4097, 14000));
                    default: sz = 32'($urandom_range(1, 200));
                endcase
                if (($urandom % 4) == 0) off = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
                else                     off = {$urandom, $urandom};
                set_job(i, off, sz);
                if (($urandom % 2) == 0) j_pend[i] = 1'b1;
                else if (($urandom % 2) == 0) j_raise[i] = cyc + int'($urandom_range(1, 30));
            end
            drive();
            run_until_idle(2000);
            check_perf();
        end

        // Reset while waiting on the datapath drops the job without completion.
        lat_rand = 1'b0;
        lat_fix  = 20;
        set_job(1, 64'h0000_0000_3000_0000, 32'd8192);
        j_pend[1] = 1'b1;
        drive();
        repeat (5) step();
        chk("wait_busy", 64'(busy), 64'd1);
        do_reset();
        repeat (6) step();
        check_perf();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
